// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC and runs a single-outstanding req/ack
// master on the instruction bus, presenting (if_pc, if_inst) to IF/ID.
module if_fetch #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        stall,
    input  logic              flush,
    input  logic [ADDR_W-1:0] new_pc,
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] branch_target_address_i,
    output logic              ibus_req,
    output logic [ADDR_W-1:0] ibus_addr,
    input  logic [DATA_W-1:0] ibus_rdata,
    input  logic              ibus_ack,
    output logic [ADDR_W-1:0] if_pc,
    output logic [DATA_W-1:0] if_inst,
    output logic              stallreq
);

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] pc, pc_n;
    logic [ADDR_W-1:0] req_addr, req_addr_n;
    logic [ADDR_W-1:0] next_pc;
    logic [DATA_W-1:0] hold_inst, hold_inst_n;
    logic              unused_bits;

    assign unused_bits = ^{stall[5:1], new_pc[1:0], branch_target_address_i[1:0]};

    function automatic logic [ADDR_W-1:0] align(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:2], 2'b00};
    endfunction

    assign next_pc = branch_flag_i ? align(branch_target_address_i) : pc + ADDR_W'(4);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= FETCH;
            pc        <= align(RESET_PC);
            req_addr  <= '0;
            hold_inst <= '0;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            req_addr  <= req_addr_n;
            hold_inst <= hold_inst_n;
        end
    end

    always_comb begin
        state_n     = state;
        pc_n        = pc;
        req_addr_n  = req_addr;
        hold_inst_n = hold_inst;
        ibus_req    = 1'b0;
        ibus_addr   = pc;
        if_pc       = '0;
        if_inst     = '0;
        stallreq    = 1'b0;

        case (state)
            FETCH: begin
                ibus_req = 1'b1;
                if (flush) begin
                    pc_n = align(new_pc);
                    // Request still open: keep its address on the bus until the ack drains it.
                    if (!ibus_ack) begin
                        state_n    = DISCARD;
                        req_addr_n = pc;
                        stallreq   = 1'b1;
                    end
                end else if (ibus_ack) begin
                    if_pc   = pc;
                    if_inst = ibus_rdata;
                    if (stall[0]) begin
                        hold_inst_n = ibus_rdata;
                        state_n     = HOLD;
                    end else begin
                        pc_n = next_pc;
                    end
                end else begin
                    stallreq = 1'b1;
                end
            end
            HOLD: begin
                if_pc   = pc;
                if_inst = hold_inst;
                if (flush) begin
                    pc_n        = align(new_pc);
                    hold_inst_n = '0;
                    state_n     = FETCH;
                end else if (!stall[0]) begin
                    pc_n    = next_pc;
                    state_n = FETCH;
                end
            end
            DISCARD: begin
                ibus_req  = 1'b1;
                ibus_addr = req_addr;
                stallreq  = 1'b1;
                if (flush) begin
                    pc_n = align(new_pc);
                end
                if (ibus_ack) begin
                    state_n = FETCH;
                end
            end
            default: begin
                state_n = FETCH;
            end
        endcase

        if (!rst) begin
            ibus_req = 1'b0;
            stallreq = 1'b0;
            if_pc    = '0;
            if_inst  = '0;
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Directed-vector bench for if_fetch; each task drives one scenario and
// compares the packed bus/pipeline outputs against hand-computed values.
module tb_if_fetch;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        branch_flag_i;
    logic [31:0] branch_target_address_i;
    logic        ibus_req;
    logic [31:0] ibus_addr;
    logic [31:0] ibus_rdata;
    logic        ibus_ack;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        stallreq;

    int vectors;
    int miscompares;
    logic [103:0] exp;

    if_fetch #(
        .RESET_PC (32'h0000_0000),
        .ADDR_W   (32),
        .DATA_W   (32)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .stall                   (stall),
        .flush                   (flush),
        .new_pc                  (new_pc),
        .branch_flag_i           (branch_flag_i),
        .branch_target_address_i (branch_target_address_i),
        .ibus_req                (ibus_req),
        .ibus_addr               (ibus_addr),
        .ibus_rdata              (ibus_rdata),
        .ibus_ack                (ibus_ack),
        .if_pc                   (if_pc),
        .if_inst                 (if_inst),
        .stallreq                (stallreq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // {req, addr, if_pc, if_inst, stallreq}, nibble-padded for readable hex
    function automatic logic [103:0] pk(input logic r, input logic [31:0] a,
                                        input logic [31:0] p, input logic [31:0] i,
                                        input logic s);
        return {3'b000, r, a, p, i, 3'b000, s};
    endfunction

    function automatic logic [103:0] obs();
        return {3'b000, ibus_req, ibus_addr, if_pc, if_inst, 3'b000, stallreq};
    endfunction

    task automatic drive(input logic a, input logic [31:0] d, input logic s,
                         input logic f, input logic [31:0] np,
                         input logic b, input logic [31:0] t);
        ibus_ack                = a;
        ibus_rdata              = d;
        stall                   = {5'b0, s};
        flush                   = f;
        new_pc                  = np;
        branch_flag_i           = b;
        branch_target_address_i = t;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle();
        tick();
        tick();
        rst = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(1'b1, 32'hBAD0_BAD0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        exp = pk(1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        if (obs() !== exp) begin $display("FAIL reset_forced: got %h expected %h", obs(), exp); miscompares++; end
        vectors++;
        tick();
        if (obs() !== exp) begin $display("FAIL reset_edge: got %h expected %h", obs(), exp); miscompares++; end
        vectors++;
        idle();
        rst = 1'b1;
        #1;
        exp = pk(1'b1, 32'h0, 32'h0, 32'h0, 1'b1);
        if (obs() !== exp) begin $display("FAIL reset_release: got %h expected %h", obs(), exp); miscompares++; end
        vectors++;
    endtask

    task automatic test_stream();
        drive(1'b1, 32'h11, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        exp = pk(1'b1, 32'h0, 32'h0, 32'h11, 1'b0);
        if (obs() !== exp) begin $display("FAIL stream_0: got %h expected %h", obs(), exp); miscompares++; end
        vectors++;
        tick();
        drive(1'b1, 32'h22, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        exp = pk(1'b1, 32'h4, 32'h4, 32'h22, 1'b0);
        if (obs() !== exp) begin $display("FAIL stream_4: got %h expected %h", obs(), exp); miscompares++; end
        vectors++;
        tick();
        drive(1'b1, 32'h33, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        exp = pk(1'b1, 32'h8, 32'h8, 32'h33, 1'b0);
        if (obs() !== exp) begin $display("FAIL stream_8: got %h expected %h", obs(), exp); miscompares++; end
        vectors++;
        tick();
    endtask

    task automatic test_wait_states();
        do_reset();
        drive(1'b1, 32'h11, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        for (int i = 0; i < 2; i++) begin
            idle();
            exp = pk(1'b1, 32'h4, 32'h0, 32'h0, 1'b1);
            if (obs() !== exp) begin $display("FAIL wait_cycle%0d: got %h expected %h", i, obs(), exp); miscompares++; end
            vectors++;
            tick();
        end
        drive(1'b1, 32'h22, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        exp = pk(1'b1, 32'h4, 32'h4, 32'h22, 1'b0);
        if (obs() !== exp) begin $display("FAIL wait_ack: got %h expected %h", obs(), exp); miscompares++; end
        vectors++;
        tick();
        idle();
        exp = pk(1'b1, 32'h8, 32'h0, 32'h0, 1'b1);
        if (obs() !== exp) begin $display("FAIL wait_next: got %h expected %h", obs(), exp); miscompares++; end
        vectors++;
    endtask

    task automatic test_hold();
        drive(1'b1, 32'hA5, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        exp = pk(1'b1, 32'h8, 32'h8, 32'hA5, 1'b0);
        if (obs() !== exp) begin $display("FAIL hold_ack: got %h expected %h", obs(), exp); miscompares++; end
        vectors++;
        tick();
        for (int i = 0; i < 3; i++) begin
            // stray ack with junk data in the middle cycle must be ignored
            drive((i == 1), 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
            exp = pk(1'b0, 32'h8, 32'h8, 32'hA5, 1'b0);
            if (obs() !== exp) begin $display("FAIL hold_cycle%0d: got %h expected %h", i, obs(), exp); miscompares++; end
            vectors++;
            tick();
        end
        idle();
        exp = pk(1'b0, 32'h8, 32'h8, 32'hA5, 1'b0);
        if (obs() !== exp) begin $display("FAIL hold_release: got %h expected %h", obs(), exp); miscompares++; end
        vectors++;
        tick();
        idle();
        exp = pk(1'b1, 32'hC, 32'h0, 32'h0, 1'b1);
        if (obs() !== exp) begin $display("FAIL hold_next_req: got %h expected %h", obs(), exp); miscompares++; end
        vectors++;
        drive(1'b1, 32'h55, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        exp = pk(1'b1, 32'hC, 32'hC, 32'h55, 1'b0);
        if (obs() !== exp) begin $display("FAIL hold_consume_c: got %h expected %h", obs(), exp); miscompares++; end
        vectors++;
        tick();
    endtask

    task automatic test_flush_outstanding();
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h180, 1'b0, 32'h0);
        exp = pk(1'b1, 32'h10, 32'h0, 32'h0, 1'b1);
        if (obs() !== exp) begin $display("FAIL flush_req: got %h expected %h", obs(), exp); miscompares++; end
        vectors++;
        tick();
        idle();
        exp = pk(1'b1, 32'h10, 32'h0, 32'h0, 1'b1);
        if (obs() !== exp) begin $display("FAIL discard_wait: got %h expected %h", obs(), exp); miscompares++; end
        vectors++;
        tick();
        drive(1'b1, 32'hDEAD, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        exp = pk(1'b1, 32'h10, 32'h0, 32'h0, 1'b1);
        if (obs() !== exp) begin $display("FAIL discard_ack: got %h expected %h", obs(), exp); miscompares++; end
        vectors++;
        tick();
        idle();
        exp = pk(1'b1, 32'h180, 32'h0, 32'h0, 1'b1);
        if (obs() !== exp) begin $display("FAIL flush_new_req: got %h expected %h", obs(), exp); miscompares++; end
        vectors++;
    endtask

    task automatic test_branch();
        drive(1'b1, 32'hBEEF, 1'b0, 1'b1, 32'h20, 1'b0, 32'h0);
        exp = pk(1'b1, 32'h180, 32'h0, 32'h0, 1'b0);
        if (obs() !== exp) begin $display("FAIL flush_with_ack: got %h expected %h", obs(), exp); miscompares++; end
        vectors++;
        tick();
        drive(1'b1, 32'h66, 1'b0, 1'b0, 32'h0, 1'b1, 32'h400);
        exp = pk(1'b1, 32'h20, 32'h20, 32'h66, 1'b0);
        if (obs() !== exp) begin $display("FAIL branch_delay_slot: got %h expected %h", obs(), exp); miscompares++; end
        vectors++;
        tick();
        idle();
        exp = pk(1'b1, 32'h400, 32'h0, 32'h0, 1'b1);
        if (obs() !== exp) begin $display("FAIL branch_target_req: got %h expected %h", obs(), exp); miscompares++; end
        vectors++;
        drive(1'b1, 32'h77, 1'b0, 1'b1, 32'h183, 1'b1, 32'h800);
        exp = pk(1'b1, 32'h400, 32'h0, 32'h0, 1'b0);
        if (obs() !== exp) begin $display("FAIL branch_flush_same: got %h expected %h", obs(), exp); miscompares++; end
        vectors++;
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h800);
        exp = pk(1'b1, 32'h180, 32'h0, 32'h0, 1'b1);
        if (obs() !== exp) begin $display("FAIL flush_wins: got %h expected %h", obs(), exp); miscompares++; end
        vectors++;
        tick();
        idle();
        exp = pk(1'b1, 32'h180, 32'h0, 32'h0, 1'b1);
        if (obs() !== exp) begin $display("FAIL branch_no_consume: got %h expected %h", obs(), exp); miscompares++; end
        vectors++;
        drive(1'b1, 32'h88, 1'b0, 1'b0, 32'h0, 1'b1, 32'h403);
        tick();
        idle();
        exp = pk(1'b1, 32'h400, 32'h0, 32'h0, 1'b1);
        if (obs() !== exp) begin $display("FAIL branch_align: got %h expected %h", obs(), exp); miscompares++; end
        vectors++;
    endtask

    task automatic test_wrap();
        drive(1'b1, 32'h99, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
        tick();
        drive(1'b1, 32'h12, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        exp = pk(1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h12, 1'b0);
        if (obs() !== exp) begin $display("FAIL wrap_top: got %h expected %h", obs(), exp); miscompares++; end
        vectors++;
        tick();
        idle();
        exp = pk(1'b1, 32'h0, 32'h0, 32'h0, 1'b1);
        if (obs() !== exp) begin $display("FAIL wrap_zero: got %h expected %h", obs(), exp); miscompares++; end
        vectors++;
        drive(1'b1, 32'h13, 1'b0, 1'b1, 32'h24, 1'b0, 32'h0);
        tick();
    endtask

    task automatic test_async_reset();
        idle();
        exp = pk(1'b1, 32'h24, 32'h0, 32'h0, 1'b1);
        if (obs() !== exp) begin $display("FAIL areset_pre: got %h expected %h", obs(), exp); miscompares++; end
        vectors++;
        tick();
        rst = 1'b0;
        #1;
        exp = pk(1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        if (obs() !== exp) begin $display("FAIL areset_immediate: got %h expected %h", obs(), exp); miscompares++; end
        vectors++;
        drive(1'b1, 32'hBAD1_BAD1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        if (obs() !== exp) begin $display("FAIL areset_stray_ack: got %h expected %h", obs(), exp); miscompares++; end
        vectors++;
        idle();
        rst = 1'b1;
        #1;
        exp = pk(1'b1, 32'h0, 32'h0, 32'h0, 1'b1);
        if (obs() !== exp) begin $display("FAIL areset_release: got %h expected %h", obs(), exp); miscompares++; end
        vectors++;
        drive(1'b1, 32'h11, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        exp = pk(1'b1, 32'h0, 32'h0, 32'h11, 1'b0);
        if (obs() !== exp) begin $display("FAIL areset_first: got %h expected %h", obs(), exp); miscompares++; end
        vectors++;
        tick();
        idle();
        exp = pk(1'b1, 32'h4, 32'h0, 32'h0, 1'b1);
        if (obs() !== exp) begin $display("FAIL areset_next: got %h expected %h", obs(), exp); miscompares++; end
        vectors++;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        idle();
        test_reset();
        test_stream();
        test_wait_states();
        test_hold();
        test_flush_outstanding();
        test_branch();
        test_wrap();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage directly upstream of the IF/ID pipeline register.
- Owns the PC and runs a single-outstanding request/acknowledge master on the instruction bus.
- Presents (if_pc, if_inst) for IF/ID to sample, and asserts stallreq to the pipeline controller while an instruction is not yet available.
- Handles exception flush (new_pc) and branch redirect with MIPS delay-slot semantics.

Parameters:
- RESET_PC, 32'h0000_0000: PC loaded on reset.
- ADDR_W, 32: PC and bus address width.
- DATA_W, 32: instruction width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-low (rst=0 resets)
- stall  in  6  controller stall vector; stall[0]=1 holds this stage
- flush  in  1  exception flush; redirect to new_pc
- new_pc  in  ADDR_W  exception handler address
- branch_flag_i  in  1  branch taken, from decode
- branch_target_address_i  in  ADDR_W  branch target
- ibus_req  out  1  instruction bus request
- ibus_addr  out  ADDR_W  request address, bits [1:0] forced 0
- ibus_rdata  in  DATA_W  instruction data, valid when ibus_ack=1
- ibus_ack  in  1  single-cycle acknowledge for an outstanding request
- if_pc  out  ADDR_W  PC of the presented instruction; 0 when none
- if_inst  out  DATA_W  presented instruction; 0 (nop) when none
- stallreq  out  1  instruction not available this cycle

Behaviour:
- Reset (rst=0, async):
  - pc=RESET_PC, state=FETCH, hold_inst=0.
  - ibus_req=0, stallreq=0, if_pc=0, if_inst=0, all forced while rst=0.
  - A reset mid-transaction abandons the request; the bus ignores the orphaned ack.
- State FETCH:
  - ibus_req=1, ibus_addr=pc.
  - ack=0: if_pc=if_inst=0, stallreq=1.
  - ack=1: if_pc=pc, if_inst=ibus_rdata combinationally in the same cycle, stallreq=0.
    - stall[0]=0 (consumed): pc <= next_pc, stay in FETCH. Zero-wait memory gives one instruction per cycle.
    - stall[0]=1: hold_inst <= ibus_rdata, go to HOLD.
- State HOLD:
  - ibus_req=0, if_pc=pc, if_inst=hold_inst, stallreq=0.
  - Stays until stall[0]=0, then pc <= next_pc and go to FETCH.
- State DISCARD:
  - A redirect arrived while a request was outstanding.
  - ibus_req=1 with ibus_addr held at the old address (bus rule: req/addr stable until ack).
  - if_pc=if_inst=0, stallreq=1.
  - On ack, data is dropped and state goes to FETCH; the new pc is already loaded.
- next_pc at a consume event: branch_flag_i ? branch_target_address_i : pc+4, mod 2^ADDR_W (wrap, no trap).
  - The consumed instruction is the delay slot and is always delivered.
  - branch_flag_i is ignored when no consume occurs; decode holds it until consumption.
- Flush (highest priority, regardless of stall):
  - pc <= new_pc.
  - FETCH with ack=0 -> DISCARD. FETCH with ack=1 -> FETCH, data dropped, if_pc/if_inst=0 that cycle.
  - HOLD -> FETCH, hold_inst discarded.
  - DISCARD -> stay in DISCARD, pc updated.
  - flush and branch_flag_i together: flush wins.
- Only one request is ever outstanding; ibus_ack outside a request is ignored.
- Low two bits of new_pc and branch target are ignored; the PC is always word-aligned.

Test Plan:
1. Reset release, ack tied to req, instructions at 0x0/0x4/0x8 = 0x11/0x22/0x33 -> if_pc 0,4,8 on consecutive cycles, if_inst matches, stallreq never 1.
2. Memory acks 2 cycles after req for addr 0x4 -> stallreq=1 and if_inst=0 for 2 cycles, then if_pc=0x4 with data; pc advances to 0x8.
3. Ack for 0x8 (data 0xA5) with stall[0]=1 for 3 cycles -> ibus_req=0, if_inst=0xA5 stable 3 cycles, no refetch; on release, next req addr=0xC.
4. Request at 0x10 outstanding, flush=1 with new_pc=0x180 -> ibus_addr stays 0x10 until ack, data not presented, next req addr=0x180.
5. Instruction at 0x20 consumed with branch_flag_i=1 and target 0x400 -> 0x20 delivered, next req addr=0x400; same cycle plus flush (new_pc=0x180) -> next req addr=0x180.
6. rst low during a wait at 0x24 -> outputs 0 immediately (async); after release, first req addr=RESET_PC; stray ack for the old request is ignored.
